// File: rtl/operand_loader.sv
// operand_loader: button-driven loader of ALU operands A, B and selector S.
// Define OPERAND_LOADER_DEBOUNCE_EN to enable the btn_next debounce filter.
module operand_loader #(
  parameter int N = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic [4:0]   sel_sw,
  input  logic         btn_next,
  input  logic         btn_clr,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [4:0]   S,
  output logic         valid,
  output logic [1:0]   stage
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, RUN} state_t;
  state_t state, state_d;
  logic [N-1:0] a_d, b_d;
  logic [4:0] s_d;
  logic [1:0] next_sync, clr_sync;
  logic deb, deb_d, adv, clr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_sync <= '0;
      clr_sync <= '0;
    end else begin
      next_sync <= {next_sync[0], btn_next};
      clr_sync <= {clr_sync[0], btn_clr};
    end
  end
  assign clr = clr_sync[1];
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt, cnt_d;
  // The level flips on the cycle the differing run would reach DEBOUNCE_CYCLES, so cnt tops out at LAST.
  always_comb begin
    cnt_d = (next_sync[1] == deb || cnt == LAST) ? '0 : cnt + 1'b1;
    deb_d = (next_sync[1] != deb && cnt == LAST) ? ~deb : deb;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      deb <= deb_d;
      cnt <= cnt_d;
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign deb = next_sync[1];
  assign deb_d = next_sync[0];
`endif
  // Event fires on the same edge the debounced level rises, so the capture lands on that edge.
  assign adv = deb_d & ~deb;
  always_comb begin
    state_d = state;
    a_d = A;
    b_d = B;
    s_d = S;
    if (clr) begin
      state_d = LOAD_A;
      a_d = '0;
      b_d = '0;
      s_d = '0;
    end else if (adv) begin
      state_d = state_t'(state + 2'd1);
      a_d = (state == LOAD_A) ? sw : A;
      b_d = (state == LOAD_B) ? sw : B;
      s_d = (state == LOAD_OP) ? sel_sw : S;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      A <= '0;
      B <= '0;
      S <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_d;
      A <= a_d;
      B <= b_d;
      S <= s_d;
      valid <= (state_d == RUN);
    end
  end
  assign stage = state;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed bench for operand_loader with a scoreboard of expected outputs.
module tb_operand_loader;
  localparam int N = 4;
  localparam int D = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 2;
`endif
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [4:0]   s;
    logic [1:0]   st;
    logic         v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] sw = '0;
  logic [4:0] sel_sw = '0;
  logic btn_next = 1'b0;
  logic btn_clr = 1'b0;
  logic [N-1:0] A, B;
  logic [4:0] S;
  logic valid;
  logic [1:0] stage;
  logic [N-1:0] ma = '0, mb = '0;
  logic [4:0] ms = '0;
  logic [1:0] mst = '0;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  operand_loader #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sel_sw(sel_sw),
    .btn_next(btn_next), .btn_clr(btn_clr),
    .A(A), .B(B), .S(S), .valid(valid), .stage(stage)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: bench did not finish");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    sb.push_back('{ma, mb, ms, mst, mst == 2'd3});
  endtask

  task automatic model_zero();
    ma = '0;
    mb = '0;
    ms = '0;
    mst = '0;
  endtask

  task automatic model_adv();
    case (mst)
      2'd0: begin ma = sw; mst = 2'd1; end
      2'd1: begin mb = sw; mst = 2'd2; end
      2'd2: begin ms = sel_sw; mst = 2'd3; end
      default: mst = 2'd0;
    endcase
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".A"}, 8'(A), 8'(e.a));
      chk({tag, ".B"}, 8'(B), 8'(e.b));
      chk({tag, ".S"}, 8'(S), 8'(e.s));
      chk({tag, ".stage"}, 8'(stage), 8'(e.st));
      chk({tag, ".valid"}, 8'(valid), 8'(e.v));
    end
  endtask

  // Outputs must hold one cycle before the expected latency and change exactly at it.
  task automatic press(input int hold, input string tag);
    push_model();
    model_adv();
    push_model();
    btn_next = 1'b1;
    tick(LAT - 1);
    pop_check({tag, ".early"});
    tick(1);
    pop_check({tag, ".edge"});
    tick(hold);
    btn_next = 1'b0;
    push_model();
    tick(LAT + 2);
    pop_check({tag, ".release"});
  endtask

  initial begin
    tick(2);
    push_model();
    pop_check("reset");
    rst_n = 1'b1;
    tick(2);

    sw = 4'h7;
    press(3, "loadA");
    sw = 4'h3;
    press(3, "loadB");
    sel_sw = 5'h02;
    press(3, "loadOp");

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    sw = 4'hf;
    sel_sw = 5'h1f;
    for (int w = 1; w <= 3; w++) begin
      btn_next = 1'b1;
      tick(w);
      btn_next = 1'b0;
      tick(LAT + 2);
    end
    repeat (4) begin
      btn_next = 1'b1;
      tick(3);
      btn_next = 1'b0;
      tick(1);
    end
    tick(LAT + 2);
    push_model();
    pop_check("chatter");
`endif

    press(2, "runWrap");

    sw = 4'h5;
    press(2, "loadA2");
    sw = 4'h9;
    push_model();
    if (LAT >= 3) begin
      btn_next = 1'b1;
      tick(LAT - 3);
      btn_clr = 1'b1;
      tick(2);
    end else begin
      btn_clr = 1'b1;
      tick(1);
      btn_next = 1'b1;
      tick(1);
    end
    pop_check("clr.pre");
    model_zero();
    push_model();
    tick(1);
    pop_check("clr.same");
    tick(5);
    btn_clr = 1'b0;
    tick(LAT + 4);
    push_model();
    pop_check("clr.held_press");
    btn_next = 1'b0;
    tick(LAT + 2);
    sw = 4'h6;
    press(2, "afterClrA");
    sw = 4'h1;
    press(2, "afterClrB");

    btn_next = 1'b1;
    tick(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_zero();
    push_model();
    pop_check("async_rst");
    btn_next = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(LAT + 3);
    push_model();
    pop_check("post_rst");
    sw = 4'h8;
    press(2, "freshA");

    sw = 4'hc;
    press(100, "hold100");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
